// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: groups the ID->EX control bus of alu_ctrl_seq.
//   master: upstream decoder/bench side (drives id_valid, ALUOp, funct, flush)
//   slave : alu_ctrl_seq side (drives ALUSel, ex_valid, illegal, mc_start,
//           mc_done, stall)
interface alu_ctrl_seq_if #(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned FUNCT_W = 6
);
  logic               id_valid;
  logic [1:0]         ALUOp;
  logic [FUNCT_W-1:0] funct;
  logic               flush;
  logic [SEL_W-1:0]   ALUSel;
  logic               ex_valid;
  logic               illegal;
  logic               mc_start;
  logic               mc_done;
  logic               stall;

  modport master (
    output id_valid, ALUOp, funct, flush,
    input  ALUSel, ex_valid, illegal, mc_start, mc_done, stall
  );

  modport slave (
    input  id_valid, ALUOp, funct, flush,
    output ALUSel, ex_valid, illegal, mc_start, mc_done, stall
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control unit at the ID->EX boundary.
// Decodes ALUOp/funct into an ALU select and sequences multi-cycle ops
// (MULT, and DIV when ALU_CTRL_DIV_EN is defined), holding stall for N cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : alu_ctrl_seq_if.slave
//          in : id_valid, ALUOp[1:0], funct[FUNCT_W-1:0], flush
//          out: ALUSel[SEL_W-1:0], ex_valid, illegal, mc_start (registered),
//               mc_done, stall (derived from FSM state)
// Optional feature macro: ALU_CTRL_DIV_EN (funct 011010 -> DIV, DIV_CYCLES stall)
module alu_ctrl_seq #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_ctrl_seq_if.slave bus
);

  localparam int unsigned MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_N + 1);

  typedef enum logic {IDLE, MULTI} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   alusel_q;
  logic               ex_valid_q;
  logic               illegal_q;
  logic               mc_start_q;

  logic [SEL_W-1:0]   dec_sel;
  logic               dec_ill;
  logic               dec_mc;
  logic [CNT_W-1:0]   dec_n;

  always_comb begin
    dec_sel = SEL_W'(4'b0010);
    dec_ill = 1'b0;
    dec_mc  = 1'b0;
    dec_n   = '0;
    case (bus.ALUOp)
      2'b00: dec_sel = SEL_W'(4'b0010);
      2'b01: dec_sel = SEL_W'(4'b0110);
      2'b10: begin
        case (bus.funct)
          FUNCT_W'(6'b100100): dec_sel = SEL_W'(4'b0000);
          FUNCT_W'(6'b100101): dec_sel = SEL_W'(4'b0001);
          FUNCT_W'(6'b100000): dec_sel = SEL_W'(4'b0010);
          FUNCT_W'(6'b000000): dec_sel = SEL_W'(4'b0011);
          FUNCT_W'(6'b000010): dec_sel = SEL_W'(4'b0100);
          FUNCT_W'(6'b100010): dec_sel = SEL_W'(4'b0110);
          FUNCT_W'(6'b101010): dec_sel = SEL_W'(4'b0111);
          FUNCT_W'(6'b000100): dec_sel = SEL_W'(4'b1000);
          FUNCT_W'(6'b000110): dec_sel = SEL_W'(4'b1001);
          FUNCT_W'(6'b000111): dec_sel = SEL_W'(4'b1010);
          FUNCT_W'(6'b011000): begin
            dec_sel = SEL_W'(4'b1011);
            dec_mc  = 1'b1;
            dec_n   = CNT_W'(MUL_CYCLES - 1);
          end
`ifdef ALU_CTRL_DIV_EN
          FUNCT_W'(6'b011010): begin
            dec_sel = SEL_W'(4'b1100);
            dec_mc  = 1'b1;
            dec_n   = CNT_W'(DIV_CYCLES - 1);
          end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alusel_q   <= '0;
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      mc_start_q <= 1'b0;
    end else if (bus.flush) begin
      // ALUSel deliberately holds across a flush.
      state_q    <= IDLE;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      mc_start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mc_start_q <= 1'b0;
          if (bus.id_valid) begin
            alusel_q   <= dec_sel;
            illegal_q  <= dec_ill;
            ex_valid_q <= 1'b1;
            // dec_mc is never set together with dec_ill.
            if (dec_mc) begin
              mc_start_q <= 1'b1;
              cnt_q      <= dec_n;
              state_q    <= MULTI;
            end
          end else begin
            ex_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
          end
        end
        MULTI: begin
          ex_valid_q <= 1'b0;
          illegal_q  <= 1'b0;
          mc_start_q <= 1'b0;
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ALUSel   = alusel_q;
  assign bus.ex_valid = ex_valid_q;
  assign bus.illegal  = illegal_q;
  assign bus.mc_start = mc_start_q;
  assign bus.stall    = (state_q == MULTI);
  // A flush landing in the final cycle aborts the op, so no completion is reported.
  assign bus.mc_done  = (state_q == MULTI) && (cnt_q == '0) && !bus.flush;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned MUL_CYCLES = 4;
  localparam int unsigned DIV_CYCLES = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [SEL_W-1:0] exp_sel = '0;

  alu_ctrl_seq_if #(.SEL_W(SEL_W), .FUNCT_W(FUNCT_W)) bus ();

  alu_ctrl_seq #(
    .SEL_W(SEL_W), .FUNCT_W(FUNCT_W),
    .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference decode table: legal R-type functs and their ALU selects.
  logic [5:0] fn_tab  [0:10] = '{6'h24, 6'h25, 6'h20, 6'h00, 6'h02, 6'h22,
                                 6'h2A, 6'h04, 6'h06, 6'h07, 6'h18};
  logic [3:0] sel_tab [0:10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6,
                                 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

  task automatic ref_decode(input logic [1:0] op, input logic [5:0] fn,
                            output logic [3:0] sel, output logic ill,
                            output int unsigned n);
    sel = 4'd2; ill = 1'b0; n = 0;
    if (op == 2'd1) sel = 4'd6;
    else if (op == 2'd3) ill = 1'b1;
    else if (op == 2'd2) begin
      ill = 1'b1;
      for (int i = 0; i < 11; i++)
        if (fn_tab[i] == fn) begin sel = sel_tab[i]; ill = 1'b0; end
      if (fn == 6'h18) n = MUL_CYCLES;
`ifdef ALU_CTRL_DIV_EN
      if (fn == 6'h1A) begin sel = 4'd12; ill = 1'b0; n = DIV_CYCLES; end
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 0);
    chk({tag, ".illegal"},  32'(bus.illegal), 0);
    chk({tag, ".mc_start"}, 32'(bus.mc_start), 0);
    chk({tag, ".stall"},    32'(bus.stall), 0);
    chk({tag, ".mc_done"},  32'(bus.mc_done), 0);
    chk({tag, ".ALUSel"},   32'(bus.ALUSel), 32'(exp_sel));
  endtask

  task automatic idle_cycle();
    bus.id_valid = 1'b0;
    bus.ALUOp    = 2'($urandom);
    bus.funct    = 6'($urandom);
    tick();
    chk_idle("idle");
  endtask

  // Issue one op from IDLE and follow it until the first IDLE cycle after it.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] s; logic ill; int unsigned n;
    ref_decode(op, fn, s, ill, n);
    bus.id_valid = 1'b1; bus.ALUOp = op; bus.funct = fn; bus.flush = 1'b0;
    tick();
    exp_sel = s;
    chk("acc.ex_valid", 32'(bus.ex_valid), 1);
    chk("acc.ALUSel",   32'(bus.ALUSel), 32'(s));
    chk("acc.illegal",  32'(bus.illegal), 32'(ill));
    chk("acc.mc_start", 32'(bus.mc_start), 32'(n != 0));
    chk("acc.stall",    32'(bus.stall), 32'(n != 0));
    for (int unsigned k = 0; k < n; k++) begin
      bus.id_valid = 1'($urandom);
      bus.ALUOp    = 2'($urandom);
      bus.funct    = 6'($urandom);
      chk("mc.stall",    32'(bus.stall), 1);
      chk("mc.mc_done",  32'(bus.mc_done), 32'(k == n - 1));
      chk("mc.ALUSel",   32'(bus.ALUSel), 32'(s));
      chk("mc.ex_valid", 32'(bus.ex_valid), 32'(k == 0));
      chk("mc.mc_start", 32'(bus.mc_start), 32'(k == 0));
      tick();
    end
    if (n != 0) chk_idle("post_mc");
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] fn;
    bus.id_valid = 1'b0; bus.ALUOp = '0; bus.funct = '0; bus.flush = 1'b0;

    // Reset state
    #1;
    chk_idle("reset");
    tick();
    rst = 1'b0;
    idle_cycle();

    // Async reset in the middle of a MULT
    bus.id_valid = 1'b1; bus.ALUOp = 2'd2; bus.funct = 6'h18;
    tick();
    bus.id_valid = 1'b0;
    chk("t1.stall0", 32'(bus.stall), 1);
    tick();
    #2 rst = 1'b1;
    #1;
    exp_sel = '0;
    chk_idle("t1.rst");
    #2 rst = 1'b0;
    tick();
    chk_idle("t1.release");

    // Sweep every ALUOp and every funct under ALUOp=10
    for (int a = 0; a < 4; a++) issue(2'(a), 6'($urandom));
    for (int f = 0; f < 64; f++) issue(2'd2, 6'(f));
    idle_cycle();

    // MULT, then a new op accepted in the first IDLE cycle
    issue(2'd2, 6'h18);
    issue(2'd1, 6'h00);
    idle_cycle();

    // Flush in the second MULTI cycle
    bus.id_valid = 1'b1; bus.ALUOp = 2'd2; bus.funct = 6'h18;
    tick();
    exp_sel = 4'd11;
    bus.id_valid = 1'b0;
    chk("t4.mc_start", 32'(bus.mc_start), 1);
    tick();
    chk("t4.stall1", 32'(bus.stall), 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_idle("t4.flushed");
    for (int i = 0; i < MUL_CYCLES; i++) idle_cycle();

    // Flush together with id_valid in IDLE drops the op
    bus.id_valid = 1'b1; bus.ALUOp = 2'd2; bus.funct = 6'h18; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_idle("t5.drop");
    idle_cycle();

    // funct 011010 (DIV or illegal depending on build)
    issue(2'd2, 6'h1A);
    idle_cycle();

    // Randomized mix of ops and idle cycles
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? fn_tab[$urandom_range(0, 10)] : 6'($urandom);
      if ($urandom_range(0, 4) == 0) idle_cycle();
      else issue(op, fn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
